// File: rtl/softreset_fill_pkg.sv
// Shared types and constants for the soft-reset / memory-fill engine.
// Imported by the beat counter and the top-level FSM.
package softreset_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INCR  = 2'd1,
        MODE_ADDR  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam logic [3:0] DEFAULT_OP_WRITE = 4'h1;

    // The reserved encoding behaves exactly like a constant fill.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        m = mode_e'(raw);
        if (m == MODE_RSVD) begin
            m = MODE_CONST;
        end
        return m;
    endfunction

endpackage

// File: rtl/softreset_fill_if.sv
// Command and arbiter-write bundles for the fill engine.
// The engine uses cmd.slave and arb.master.
interface softreset_cmd_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic              cmd_rts_in;
    logic              cmd_rtr_out;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic [1:0]        cmd_mode;

    modport master (
        output cmd_rts_in, cmd_base, cmd_len, cmd_data, cmd_mode,
        input  cmd_rtr_out
    );

    modport slave (
        input  cmd_rts_in, cmd_base, cmd_len, cmd_data, cmd_mode,
        output cmd_rtr_out
    );
endinterface

interface softreset_arb_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic              arb_rts_out;
    logic              arb_rtr_in;
    logic [ADDR_W-1:0] arb_addr;
    logic [DATA_W-1:0] arb_wr_data;
    logic [OP_W-1:0]   arb_op;

    modport master (
        output arb_rts_out, arb_addr, arb_wr_data, arb_op,
        input  arb_rtr_in
    );

    modport slave (
        input  arb_rts_out, arb_addr, arb_wr_data, arb_op,
        output arb_rtr_in
    );
endinterface

// File: rtl/softreset_fill_beat_ctr.sv
// Beat counter: tracks remaining beats and produces the registered
// address/data for the current write beat.
module softreset_beat_ctr
    import softreset_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] seed,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_next;
    logic [ADDR_W:0]   rem_reg;
    mode_e             mode_reg;
    mode_e             mode_eff;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_src;
    logic [DATA_W-1:0] addr_ext;

    assign addr_inc = addr_reg + ADDR_W'(1);
    assign addr_src = load ? base : addr_inc;
    assign mode_eff = load ? decode_mode(mode) : mode_reg;

    // Address-as-data: zero-extend or truncate the beat address to DATA_W.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_addr_ext
            if (gi < ADDR_W) begin : g_bit
                assign addr_ext[gi] = addr_src[gi];
            end else begin : g_zero
                assign addr_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        data_next = data_reg;
        if (load) begin
            data_next = (mode_eff == MODE_ADDR) ? addr_ext : seed;
        end else if (advance) begin
            case (mode_eff)
                MODE_INCR: data_next = data_reg + DATA_W'(1);
                MODE_ADDR: data_next = addr_ext;
                default:   data_next = data_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
            data_reg <= '0;
            rem_reg  <= '0;
            mode_reg <= MODE_CONST;
        end else if (load) begin
            addr_reg <= base;
            data_reg <= data_next;
            rem_reg  <= len;
            mode_reg <= decode_mode(mode);
        end else if (advance) begin
            addr_reg <= addr_inc;
            data_reg <= data_next;
            rem_reg  <= rem_reg - (ADDR_W+1)'(1);
        end
    end

    assign addr = addr_reg;
    assign data = data_reg;
    assign last = (rem_reg == (ADDR_W+1)'(1));

endmodule

// File: rtl/softreset_fill.sv
// Soft-reset / memory-fill engine: accepts one fill command, issues the
// write beats to the arbiter with sftrst_ held low, then pulses done.
module softreset_fill
    import softreset_pkg::*;
#(
    parameter int              ADDR_W      = 17,
    parameter int              DATA_W      = 32,
    parameter int              OP_W        = 4,
    parameter logic [OP_W-1:0] OP_WRITE    = OP_W'(DEFAULT_OP_WRITE),
    parameter int              HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    softreset_cmd_if.slave         cmd,
    softreset_arb_if.master        arb,
    output logic                   sftrst_,
    output logic                   done
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST =
        (HOLD_CYCLES > 0) ? HC_W'(HOLD_CYCLES - 1) : '0;
    // Where the block goes once the beats are finished (or skipped).
    localparam state_e AFTER_BEATS = (HOLD_CYCLES == 0) ? DONE : HOLD;

    state_e          state_reg;
    state_e          state_next;
    logic [HC_W-1:0] hold_cnt_reg;
    logic [HC_W-1:0] hold_cnt_next;

    logic              rtr;
    logic              accept;
    logic              beat_done;
    logic [ADDR_W-1:0] ctr_addr;
    logic [DATA_W-1:0] ctr_data;
    logic              ctr_last;

    // Ready is masked by rst so it reads 0 for the whole reset window.
    assign rtr       = (state_reg == IDLE) && !rst;
    assign accept    = cmd.cmd_rts_in && rtr;
    assign beat_done = (state_reg == ISSUE) && arb.arb_rtr_in;

    softreset_beat_ctr #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_beat_ctr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .advance (beat_done),
        .base    (cmd.cmd_base),
        .len     (cmd.cmd_len),
        .seed    (cmd.cmd_data),
        .mode    (cmd.cmd_mode),
        .addr    (ctr_addr),
        .data    (ctr_data),
        .last    (ctr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    hold_cnt_next = '0;
                    state_next    = (cmd.cmd_len != '0) ? ISSUE : AFTER_BEATS;
                end
            end
            ISSUE: begin
                if (beat_done && ctr_last) begin
                    hold_cnt_next = '0;
                    state_next    = AFTER_BEATS;
                end
            end
            HOLD: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = DONE;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HC_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state register or come straight from
    // the beat counter registers.
    assign cmd.cmd_rtr_out = rtr;
    assign arb.arb_rts_out = (state_reg == ISSUE);
    assign arb.arb_op      = (state_reg == ISSUE) ? OP_WRITE : '0;
    assign arb.arb_addr    = ctr_addr;
    assign arb.arb_wr_data = ctr_data;
    assign sftrst_         = !((state_reg == ISSUE) || (state_reg == HOLD));
    assign done            = (state_reg == DONE);

endmodule

// File: tb/tb_softreset_fill.sv
// Scoreboard bench for softreset_fill: commands push expected beats,
// a negedge monitor pops and compares every accepted write beat.
module tb_softreset_fill;
    import softreset_pkg::*;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int OW = 4;
    localparam int HC = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sftrst_;
    logic done;

    always #5 clk = ~clk;

    softreset_cmd_if #(.ADDR_W(AW), .DATA_W(DW)) cmd_bus ();
    softreset_arb_if #(.ADDR_W(AW), .DATA_W(DW), .OP_W(OW)) arb_bus ();

    softreset_fill #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .OP_W        (OW),
        .OP_WRITE    (4'h1),
        .HOLD_CYCLES (HC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cmd     (cmd_bus),
        .arb     (arb_bus),
        .sftrst_ (sftrst_),
        .done    (done)
    );

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares accepted beats and checks stability under stall.
    logic          stall_prev = 1'b0;
    logic [AW-1:0] stall_addr;
    logic [DW-1:0] stall_data;
    beat_t         mon_b;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_rts",  64'(arb_bus.arb_rts_out), 64'd1);
                check("stall_addr", 64'(arb_bus.arb_addr),    64'(stall_addr));
                check("stall_data", 64'(arb_bus.arb_wr_data), 64'(stall_data));
            end
            if (arb_bus.arb_rts_out && arb_bus.arb_rtr_in) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_beat: got addr=%0h data=%0h expected no beat",
                             arb_bus.arb_addr, arb_bus.arb_wr_data);
                end else begin
                    mon_b = exp_q.pop_front();
                    $display("[TB] beat addr=%05h data=%08h op=%0h", arb_bus.arb_addr,
                             arb_bus.arb_wr_data, arb_bus.arb_op);
                    check("beat_addr", 64'(arb_bus.arb_addr),    64'(mon_b.addr));
                    check("beat_data", 64'(arb_bus.arb_wr_data), 64'(mon_b.data));
                    check("beat_op",   64'(arb_bus.arb_op),      64'h1);
                end
            end
            stall_prev = arb_bus.arb_rts_out && !arb_bus.arb_rtr_in;
            stall_addr = arb_bus.arb_addr;
            stall_data = arb_bus.arb_wr_data;
        end
    end

    task automatic push_beats(input logic [AW-1:0] base, input logic [AW:0] len,
                              input logic [DW-1:0] data, input logic [1:0] mode);
        beat_t b;
        for (int i = 0; i < int'(len); i++) begin
            b.addr = base + AW'(i);
            case (mode)
                2'd1:    b.data = data + DW'(i);
                2'd2:    b.data = DW'(b.addr);
                default: b.data = data;
            endcase
            exp_q.push_back(b);
        end
    endtask

    // Returns #1 after the accepting edge.
    task automatic start_cmd(input logic [AW-1:0] base, input logic [AW:0] len,
                             input logic [DW-1:0] data, input logic [1:0] mode);
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_bus.cmd_rtr_out) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL cmd_ready_timeout: got rtr=0 expected 1 within 50 cycles");
        end
        $display("[TB] cmd base=%05h len=%0d data=%08h mode=%0d", base, len, data, mode);
        push_beats(base, len, data, mode);
        cmd_bus.cmd_base   = base;
        cmd_bus.cmd_len    = len;
        cmd_bus.cmd_data   = data;
        cmd_bus.cmd_mode   = mode;
        cmd_bus.cmd_rts_in = 1'b1;
        @(posedge clk);
        #1;
        cmd_bus.cmd_rts_in = 1'b0;
        check("post_accept_rts",    64'(arb_bus.arb_rts_out), 64'(len != 0));
        check("post_accept_sftrst", 64'(sftrst_),             64'd0);
        check("post_accept_rtr",    64'(cmd_bus.cmd_rtr_out), 64'd0);
    endtask

    task automatic wait_done(input int len, input int extra);
        int lat = 0;
        int low = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!sftrst_) low++;
        end
        check("done_latency", 64'(lat), 64'(len + HC + 1 + extra));
        check("sftrst_low",   64'(low), 64'(len + HC + extra));
        @(negedge clk);
        check("rtr_after_done",  64'(cmd_bus.cmd_rtr_out), 64'd1);
        check("done_one_cycle",  64'(done),                64'd0);
        check("queue_drained",   64'(exp_q.size()),        64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_bus.cmd_rts_in = 1'b0;
        cmd_bus.cmd_base   = '0;
        cmd_bus.cmd_len    = '0;
        cmd_bus.cmd_data   = '0;
        cmd_bus.cmd_mode   = '0;
        arb_bus.arb_rtr_in = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rtr",    64'(cmd_bus.cmd_rtr_out), 64'd0);
        check("rst_rts",    64'(arb_bus.arb_rts_out), 64'd0);
        check("rst_addr",   64'(arb_bus.arb_addr),    64'd0);
        check("rst_data",   64'(arb_bus.arb_wr_data), 64'd0);
        check("rst_op",     64'(arb_bus.arb_op),      64'd0);
        check("rst_sftrst", 64'(sftrst_),             64'd1);
        check("rst_done",   64'(done),                64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rtr", 64'(cmd_bus.cmd_rtr_out), 64'd1);

        // Basic fill
        start_cmd(17'h00010, 18'd4, 32'h0, 2'd0);
        wait_done(4, 0);

        // Backpressure: 3 stall cycles on beat 2
        start_cmd(17'h00010, 18'd4, 32'h0, 2'd0);
        fork
            begin
                repeat (2) @(posedge clk);
                #1 arb_bus.arb_rtr_in = 1'b0;
                repeat (3) @(posedge clk);
                #1 arb_bus.arb_rtr_in = 1'b1;
            end
            wait_done(4, 3);
        join

        // Incrementing data with address wrap, then address-as-data
        start_cmd(17'h1FFFE, 18'd4, 32'hA0, 2'd1);
        wait_done(4, 0);
        start_cmd(17'h1FFFE, 18'd4, 32'hA0, 2'd2);
        wait_done(4, 0);

        // Reserved mode acts as constant
        start_cmd(17'h00200, 18'd2, 32'h1234, 2'd3);
        wait_done(2, 0);

        // Zero length
        start_cmd(17'h00300, 18'd0, 32'hDEAD, 2'd0);
        wait_done(0, 0);

        // Command while busy must be ignored
        start_cmd(17'h00100, 18'd6, 32'h55, 2'd0);
        fork
            begin
                repeat (2) @(posedge clk);
                #1;
                cmd_bus.cmd_base   = 17'h00400;
                cmd_bus.cmd_len    = 18'd2;
                cmd_bus.cmd_data   = 32'h99;
                cmd_bus.cmd_mode   = 2'd1;
                cmd_bus.cmd_rts_in = 1'b1;
                repeat (3) @(posedge clk);
                #1 cmd_bus.cmd_rts_in = 1'b0;
            end
            wait_done(6, 0);
        join

        // Reset mid-ISSUE aborts
        start_cmd(17'h00040, 18'd8, 32'h7, 2'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_rts",    64'(arb_bus.arb_rts_out), 64'd0);
        check("abort_sftrst", 64'(sftrst_),             64'd1);
        check("abort_rtr",    64'(cmd_bus.cmd_rtr_out), 64'd1);
        check("abort_done",   64'(done),                64'd0);

        // Normal operation after the abort
        start_cmd(17'h00020, 18'd3, 32'h0, 2'd2);
        wait_done(3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/softreset_fill.md
# softreset_fill

Parametrised soft-reset and memory-fill engine; next generation of the fixed soft-reset block. Accepts one command describing a base address, word count, fill value and fill mode, then issues that many write beats to the memory arbiter while holding the soft-reset output low. Sits between the command decoder and the memory arbiter, in parallel with the other arbiter clients.

## Interface

- ADDR_W, 17, arbiter address width
- DATA_W, 32, arbiter write-data width
- OP_W, 4, arbiter opcode width
- OP_WRITE, 4'h1, opcode driven on every beat
- HOLD_CYCLES, 4, cycles sftrst_ stays low after the last beat (0 allowed)

Ports:

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_rts_in  in  1  command valid
- cmd_rtr_out  out  1  command ready; high only in IDLE
- cmd_base  in  ADDR_W  first word address
- cmd_len  in  ADDR_W+1  word count, 0..2^ADDR_W
- cmd_data  in  DATA_W  fill seed
- cmd_mode  in  2  0 constant, 1 incrementing, 2 address-as-data, 3 reserved (treated as 0)
- arb_rts_out  out  1  write beat valid
- arb_rtr_in  in  1  arbiter ready
- arb_addr  out  ADDR_W  beat address
- arb_wr_data  out  DATA_W  beat data
- arb_op  out  OP_W  beat opcode
- sftrst_  out  1  soft reset to downstream, active low
- done  out  1  one-cycle pulse on completion

## Operation

- States: IDLE, ISSUE, HOLD, DONE.
- IDLE: cmd_rtr_out=1. Command accepted on a clock edge with cmd_rts_in & cmd_rtr_out. Latch base, len, data, mode. Go to ISSUE if len!=0, else to HOLD.
- ISSUE: arb_rts_out=1, arb_op=OP_WRITE, arb_addr=base+i mod 2^ADDR_W, where i is beat index 0..len-1.
- Beat data per mode: mode 0 gives cmd_data. Mode 1 gives cmd_data+i mod 2^DATA_W. Mode 2 gives the zero-extended arb_addr, truncated if DATA_W<ADDR_W.
- A beat completes on an edge with arb_rts_out & arb_rtr_in, and i increments. After beat len-1 completes, go to HOLD.
- HOLD: count HOLD_CYCLES cycles, then go to DONE. With HOLD_CYCLES=0, HOLD lasts zero cycles and the block goes straight to DONE.
- DONE: one cycle, done=1, then IDLE.
- sftrst_=0 from the cycle after accept through the last HOLD cycle; 1 in DONE and IDLE.
- Commands presented while busy are ignored because cmd_rtr_out=0. The cmd_* inputs are sampled only at accept.
- Address wraps silently past 2^ADDR_W-1. len=2^ADDR_W writes every word exactly once.
- Reset mid-operation aborts the sequence. No partial-beat cleanup. Next cycle is IDLE with all outputs at reset values.

## Timing

- Reset values while rst=1: cmd_rtr_out=0, arb_rts_out=0, arb_addr=0, arb_wr_data=0, arb_op=0, sftrst_=1, done=0. First cycle after rst falls: IDLE, cmd_rtr_out=1.
- All outputs are registered, or decoded from the state register only. No combinational path from arb_rtr_in or cmd_rts_in to any output.
- Accept at edge N: arb_rts_out=1 and sftrst_=0 from cycle N+1.
- Throughput is one beat per cycle while arb_rtr_in=1.
- When arb_rtr_in=0, arb_addr, arb_wr_data and arb_op hold stable and arb_rts_out stays 1.
- After the last beat completes at edge M: HOLD_CYCLES cycles of HOLD, then done=1 in cycle M+1+HOLD_CYCLES. cmd_rtr_out=1 one cycle later.
- Total latency, accept to done, with arb_rtr_in tied high: len+HOLD_CYCLES+1 cycles.

## Structure

- Package softreset_pkg holds the state enum (IDLE/ISSUE/HOLD/DONE), the mode encodings (MODE_CONST, MODE_INCR, MODE_ADDR) and the default OP_WRITE.
- Sub-module softreset_beat_ctr owns the beat count and the address/data generation:
  - inputs: load, advance, base, len, seed, mode
  - outputs: addr, data, last
- The FSM, handshakes and sftrst_/done generation live in softreset_fill.

## Test plan

- Basic fill: ADDR_W=17, HOLD_CYCLES=4, arb_rtr_in=1, cmd base=0x00010, len=4, data=0, mode 0 -> beats at 0x10..0x13 with data 0, op 1. sftrst_ low 8 cycles, done pulse 9 cycles after accept.
- Backpressure: same command, arb_rtr_in low for 3 cycles during beat 2 -> addr 0x12 and its data hold stable for those 3 cycles. Exactly 4 beats total, no duplicates.
- Modes and wrap: base=0x1FFFE, len=4, data=0xA0, mode 1 -> addr 1FFFE, 1FFFF, 00000, 00001 with data A0..A3. Repeat in mode 2 -> data equals addr.
- Zero length: len=0 -> no arb_rts_out. sftrst_ low exactly HOLD_CYCLES cycles, then done.
- Busy and reset: second cmd_rts_in during ISSUE is not accepted. rst asserted mid-ISSUE -> next cycle arb_rts_out=0, sftrst_=1, cmd_rtr_out=1. A new command then runs normally.
